// File: rtl/seq_det_pkg.sv
// Shared types and the pattern-automaton transition rule for the serial pattern detector.
package seq_det_pkg;

  localparam int unsigned MAX_LEN = 32;
  localparam int unsigned STATE_W = 6;

  typedef logic [STATE_W-1:0] state_t;

  // Longest pattern prefix that is a suffix of (history for s, b). Elaboration-time only.
  function automatic int unsigned next_state(input logic [MAX_LEN-1:0] pattern,
                                             input int unsigned        len,
                                             input int unsigned        s,
                                             input logic               b,
                                             input logic               ovl);
    logic [MAX_LEN:0] seq;
    logic [63:0]      mask;
    logic [63:0]      pre;
    int unsigned      hl;
    int unsigned      best;
    hl   = (s == len && !ovl) ? 0 : s;
    seq  = '0;
    best = 0;
    for (int unsigned j = 0; j < hl; j++) begin
      seq = {seq[MAX_LEN-1:0], 1'(pattern >> (len - 1 - j))};
    end
    seq = {seq[MAX_LEN-1:0], b};
    for (int unsigned k = 1; k <= len; k++) begin
      if (k <= hl + 1) begin
        mask = (64'd1 << k) - 64'd1;
        pre  = 64'(pattern) >> (len - k);
        if ((pre & mask) == (64'(seq) & mask)) best = k;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Stream-in / detection-out bundle between the line decoder and the pattern detector.
interface seq_detect_param_if
  import seq_det_pkg::*;
#(
  parameter int unsigned CNT_W = 8
);
  logic             d_in;
  logic             d_valid;
  logic             ovl_en;
  logic             clr_cnt;
  logic             detect;
  logic [CNT_W-1:0] det_count;
  state_t           match_len;

  modport master (
    output d_in, d_valid, ovl_en, clr_cnt,
    input  detect, det_count, match_len
  );

  modport slave (
    input  d_in, d_valid, ovl_en, clr_cnt,
    output detect, det_count, match_len
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (inc_i && (q_q != {W{1'b1}})) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

// File: rtl/seq_detect_param.sv
// Parametrised Moore serial-pattern detector driven by an elaboration-built transition table.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int unsigned          LEN     = 5,
  parameter logic [MAX_LEN-1:0]   PATTERN = 32'b00101,
  parameter int unsigned          CNT_W   = 8
) (
  input logic               clk,
  input logic               rst,
  seq_detect_param_if.slave bus
);
  localparam state_t LenS = state_t'(LEN);

  if (LEN < 1 || LEN > MAX_LEN) begin : g_bad_len
    $error("seq_detect_param: LEN must be in 1..32");
  end

  // Full 64-entry table so the 6-bit state indexes it directly; rows above LEN are unreachable.
  state_t tbl [64][2][2];

  for (genvar s = 0; s < 64; s++) begin : g_row
    for (genvar b = 0; b < 2; b++) begin : g_bit
      for (genvar o = 0; o < 2; o++) begin : g_ovl
        if (s <= LEN) begin : g_live
          assign tbl[s][b][o] = state_t'(next_state(PATTERN, LEN, s, 1'(b), 1'(o)));
        end else begin : g_dead
          assign tbl[s][b][o] = '0;
        end
      end
    end
  end

  state_t state_q, state_d;
  logic   cnt_inc;

  always_comb begin
    state_d = state_q;
    cnt_inc = 1'b0;
    if (bus.d_valid) begin
      state_d = tbl[state_q][bus.d_in][bus.ovl_en];
      cnt_inc = (state_d == LenS);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= '0;
    else     state_q <= state_d;
  end

  assign bus.match_len = state_q;
  assign bus.detect    = (state_q == LenS);

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (cnt_inc),
    .clr_i (bus.clr_cnt),
    .q_o   (bus.det_count)
  );
endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: four instances share one stimulus stream; directed and random checks.
module tb_seq_detect_param;
  import seq_det_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d_in = 1'b0, d_valid = 1'b0, ovl_en = 1'b0, clr_cnt = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_detect_param_if #(.CNT_W(8)) if_a ();
  seq_detect_param_if #(.CNT_W(8)) if_b ();
  seq_detect_param_if #(.CNT_W(8)) if_c ();
  seq_detect_param_if #(.CNT_W(2)) if_d ();

  assign if_a.d_in = d_in;  assign if_a.d_valid = d_valid;
  assign if_a.ovl_en = ovl_en;  assign if_a.clr_cnt = clr_cnt;
  assign if_b.d_in = d_in;  assign if_b.d_valid = d_valid;
  assign if_b.ovl_en = ovl_en;  assign if_b.clr_cnt = clr_cnt;
  assign if_c.d_in = d_in;  assign if_c.d_valid = d_valid;
  assign if_c.ovl_en = ovl_en;  assign if_c.clr_cnt = clr_cnt;
  assign if_d.d_in = d_in;  assign if_d.d_valid = d_valid;
  assign if_d.ovl_en = ovl_en;  assign if_d.clr_cnt = clr_cnt;

  seq_detect_param #(.LEN(5), .PATTERN(32'b00101), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .bus(if_a));
  seq_detect_param #(.LEN(4), .PATTERN(32'b1011), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .bus(if_b));
  seq_detect_param #(.LEN(4), .PATTERN(32'b1111), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .bus(if_c));
  seq_detect_param #(.LEN(1), .PATTERN(32'b1), .CNT_W(2)) u_d (
    .clk(clk), .rst(rst), .bus(if_d));

  logic [5:0] obs_len [4];
  logic       obs_det [4];
  logic [7:0] obs_cnt [4];
  assign obs_len[0] = if_a.match_len;  assign obs_det[0] = if_a.detect;
  assign obs_len[1] = if_b.match_len;  assign obs_det[1] = if_b.detect;
  assign obs_len[2] = if_c.match_len;  assign obs_det[2] = if_c.detect;
  assign obs_len[3] = if_d.match_len;  assign obs_det[3] = if_d.detect;
  assign obs_cnt[0] = if_a.det_count;  assign obs_cnt[1] = if_b.det_count;
  assign obs_cnt[2] = if_c.det_count;  assign obs_cnt[3] = {6'd0, if_d.det_count};

  // Reference model: explicit bit history, match state = longest prefix/suffix overlap.
  logic [31:0] m_pat  [4] = '{32'b00101, 32'b1011, 32'b1111, 32'b1};
  int unsigned m_len  [4] = '{5, 4, 4, 1};
  int unsigned m_max  [4] = '{255, 255, 255, 3};
  logic [31:0] m_hist [4];
  int unsigned m_hl   [4];
  int unsigned m_st   [4];
  int unsigned m_cnt  [4];

  function automatic int unsigned longest(input logic [31:0] pat, input int unsigned len,
                                          input logic [31:0] hist, input int unsigned hl);
    int unsigned best = 0;
    logic        ok;
    for (int unsigned k = 1; k <= len; k++) begin
      if (k <= hl) begin
        ok = 1'b1;
        for (int unsigned i = 0; i < k; i++) begin
          if (((pat >> (len - 1 - i)) & 32'd1) != ((hist >> (k - 1 - i)) & 32'd1)) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  task automatic model_step();
    logic hit;
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        m_hist[i] = '0; m_hl[i] = 0; m_st[i] = 0; m_cnt[i] = 0;
      end else begin
        hit = 1'b0;
        if (d_valid) begin
          if (m_st[i] == m_len[i] && !ovl_en) m_hl[i] = 0;
          m_hist[i] = {m_hist[i][30:0], d_in};
          if (m_hl[i] < 32) m_hl[i]++;
          m_st[i] = longest(m_pat[i], m_len[i], m_hist[i], m_hl[i]);
          hit = (m_st[i] == m_len[i]);
        end
        if (clr_cnt) m_cnt[i] = 0;
        else if (hit && m_cnt[i] < m_max[i]) m_cnt[i]++;
      end
    end
  endtask

  task automatic send(input logic b, input logic v);
    d_in = b; d_valid = v;
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr_cnt = 1'b0;
    send(1'b1, 1'b1);
    rst = 1'b0; d_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_len[i] !== 6'd0 || obs_det[i] !== 1'b0 || obs_cnt[i] !== 8'd0) begin
        errors++;
        $display("FAIL reset inst%0d: len=%0d det=%0b cnt=%0d, want 0/0/0",
                 i, obs_len[i], obs_det[i], obs_cnt[i]);
      end
    end
  endtask

  task automatic test_basic();
    logic [4:0] bits = 5'b00101;
    logic [4:0] det  = 5'b00001;
    do_reset(); ovl_en = 1'b0;
    for (int j = 4; j >= 0; j--) begin
      send(bits[j], 1'b1);
      checks++;
      if (if_a.detect !== det[j]) begin
        errors++;
        $display("FAIL basic_detect bit%0d: got %0b want %0b", 4 - j, if_a.detect, det[j]);
      end
    end
    checks++;
    if (if_a.det_count !== 8'd1 || if_a.match_len !== 6'd5) begin
      errors++;
      $display("FAIL basic_count: cnt=%0d len=%0d want 1/5", if_a.det_count, if_a.match_len);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] bits = 7'b1011011;
    logic [6:0] det;
    for (int m = 1; m >= 0; m--) begin
      det = (m == 1) ? 7'b0001001 : 7'b0001000;
      do_reset(); ovl_en = 1'(m);
      for (int j = 6; j >= 0; j--) begin
        send(bits[j], 1'b1);
        checks++;
        if (if_b.detect !== det[j]) begin
          errors++;
          $display("FAIL ovl%0d_detect bit%0d: got %0b want %0b", m, 7 - j, if_b.detect, det[j]);
        end
      end
      checks++;
      if (if_b.det_count !== ((m == 1) ? 8'd2 : 8'd1)) begin
        errors++;
        $display("FAIL ovl%0d_count: got %0d want %0d", m, if_b.det_count, (m == 1) ? 2 : 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] det = 7'b0001111;
    do_reset(); ovl_en = 1'b1;
    for (int j = 6; j >= 0; j--) begin
      send(1'b1, 1'b1);
      checks++;
      if (if_c.detect !== det[j]) begin
        errors++;
        $display("FAIL b2b_detect bit%0d: got %0b want %0b", 7 - j, if_c.detect, det[j]);
      end
    end
    checks++;
    if (if_c.det_count !== 8'd4) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 4", if_c.det_count);
    end
  endtask

  task automatic test_stall();
    do_reset(); ovl_en = 1'b0;
    send(1'b0, 1'b1); send(1'b0, 1'b1); send(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      send(1'($urandom_range(0, 1)), 1'b0);
      checks++;
      if (if_a.match_len !== 6'd3 || if_a.detect !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: len=%0d det=%0b want 3/0", if_a.match_len, if_a.detect);
      end
    end
    send(1'b0, 1'b1); send(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (if_a.detect !== 1'b1 || if_a.det_count !== 8'd1) begin
        errors++;
        $display("FAIL stall_detect: det=%0b cnt=%0d want 1/1", if_a.detect, if_a.det_count);
      end
      ovl_en = ~ovl_en;
      send(1'b1, 1'b0);
    end
  endtask

  task automatic test_mid_reset();
    do_reset(); ovl_en = 1'b0;
    send(1'b0, 1'b1); send(1'b0, 1'b1); send(1'b1, 1'b1); send(1'b0, 1'b1);
    do_reset();
    send(1'b1, 1'b1);
    checks++;
    if (if_a.match_len !== 6'd0 || if_a.detect !== 1'b0 || if_a.det_count !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: len=%0d det=%0b cnt=%0d want 0/0/0",
               if_a.match_len, if_a.detect, if_a.det_count);
    end
  endtask

  task automatic test_saturate();
    int exp_cnt [5] = '{1, 2, 3, 3, 3};
    do_reset(); ovl_en = 1'($urandom_range(0, 1));
    for (int k = 0; k < 5; k++) begin
      send(1'b1, 1'b1);
      checks++;
      if (if_d.det_count !== 2'(exp_cnt[k]) || if_d.detect !== 1'b1) begin
        errors++;
        $display("FAIL sat_count bit%0d: cnt=%0d det=%0b want %0d/1",
                 k + 1, if_d.det_count, if_d.detect, exp_cnt[k]);
      end
    end
    clr_cnt = 1'b1;
    send(1'b1, 1'b1);
    clr_cnt = 1'b0;
    checks++;
    if (if_d.det_count !== 2'd0 || if_d.detect !== 1'b1) begin
      errors++;
      $display("FAIL clr_beats_inc: cnt=%0d det=%0b want 0/1", if_d.det_count, if_d.detect);
    end
    send(1'b0, 1'b1);
    checks++;
    if (if_d.match_len !== 6'd0 || if_d.detect !== 1'b0) begin
      errors++;
      $display("FAIL len1_miss: len=%0d det=%0b want 0/0", if_d.match_len, if_d.detect);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      ovl_en  = 1'($urandom_range(0, 1));
      clr_cnt = ($urandom_range(0, 39) == 0);
      rst     = ($urandom_range(0, 149) == 0);
      send(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_len[i] !== 6'(m_st[i]) || obs_det[i] !== (m_st[i] == m_len[i])
            || obs_cnt[i] !== 8'(m_cnt[i])) begin
          errors++;
          $display("FAIL random inst%0d cyc%0d: len=%0d det=%0b cnt=%0d want %0d/%0b/%0d",
                   i, n, obs_len[i], obs_det[i], obs_cnt[i],
                   m_st[i], (m_st[i] == m_len[i]), m_cnt[i]);
        end
      end
    end
    rst = 1'b0; clr_cnt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_back_to_back();
    test_stall();
    test_mid_reset();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
